// File: rtl/maxpool2_if.sv
// ============================================================================
// Module   : maxpool2_if
// Purpose  : Start/feature-map/pooled-map bundle between conv2, maxpool2 and
//            the next layer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface maxpool2_if #(
  parameter int SIZE      = 5,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 8
);
  localparam int OUT = SIZE / POOL;

  logic                        start;
  logic signed [WIDTH_BIT-1:0] inpMatrix [SIZE][SIZE];
  logic                        busy;
  logic                        done;
  logic signed [WIDTH_BIT-1:0] poolOut   [OUT][OUT];

  // master drives the request and feature map, slave is the pooling stage
  modport master (output start, inpMatrix, input  busy, done, poolOut);
  modport slave  (input  start, inpMatrix, output busy, done, poolOut);
endinterface

`default_nettype wire

// File: rtl/maxpool2.sv
// ============================================================================
// Module   : maxpool2
// Purpose  : POOL x POOL, stride-POOL max-pooling over a snapshot of the conv2
//            feature map, one element per clock, registered pooled map output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maxpool2 #(
  parameter int SIZE      = 5,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 8
) (
  input  wire logic   clock,
  input  wire logic   nreset,
  maxpool2_if.slave   bus
);
  localparam int OUT    = SIZE / POOL;
  localparam int c_CW   = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int c_EW   = (POOL > 1) ? $clog2(POOL * POOL) : 1;
  localparam int c_IW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [c_CW-1:0] c_CLAST = c_CW'(OUT - 1);
  localparam logic [c_EW-1:0] c_ELAST = c_EW'(POOL * POOL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      r_state;
  logic                        r_busy;
  logic                        r_done;
  logic        [c_CW-1:0]      r_row;
  logic        [c_CW-1:0]      r_col;
  logic        [c_EW-1:0]      r_elem;
  logic signed [WIDTH_BIT-1:0] r_max;
  logic signed [WIDTH_BIT-1:0] r_snap [SIZE][SIZE];
  logic signed [WIDTH_BIT-1:0] r_pool [OUT][OUT];

  logic        [c_IW-1:0]      w_rowIdx;
  logic        [c_IW-1:0]      w_colIdx;
  logic signed [WIDTH_BIT-1:0] w_elem;

  // Element e of window (r,c) in row-major order inside the window
  always_comb begin
    w_rowIdx = c_IW'(int'(r_row) * POOL + int'(r_elem) / POOL);
    w_colIdx = c_IW'(int'(r_col) * POOL + int'(r_elem) % POOL);
    w_elem   = r_snap[w_rowIdx][w_colIdx];
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_elem  <= '0;
      r_max   <= '0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          r_snap[i][j] <= '0;
      for (int i = 0; i < OUT; i++)
        for (int j = 0; j < OUT; j++)
          r_pool[i][j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_snap  <= bus.inpMatrix;
            r_row   <= '0;
            r_col   <= '0;
            r_elem  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Strict compare: ties keep the earlier element
          if (r_elem == '0 || w_elem > r_max)
            r_max <= w_elem;
          if (r_elem == c_ELAST) begin
            r_elem  <= '0;
            r_state <= S_WRITE;
          end else begin
            r_elem <= r_elem + 1'b1;
          end
        end
        S_WRITE: begin
          r_pool[r_row][r_col] <= r_max;
          if (r_row == c_CLAST && r_col == c_CLAST) begin
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (r_col == c_CLAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            r_state <= S_SCAN;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.poolOut = r_pool;

endmodule

`default_nettype wire

// File: tb/tb_maxpool2.sv
// ============================================================================
// Module   : tb_maxpool2
// Purpose  : Directed self-checking bench for maxpool2 (SIZE=5 and SIZE=7).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_maxpool2;
  localparam int SIZE      = 5;
  localparam int POOL      = 2;
  localparam int WIDTH_BIT = 8;
  localparam int SIZE7     = 7;

  logic clock  = 1'b0;
  logic nreset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  maxpool2_if #(.SIZE(SIZE),  .POOL(POOL), .WIDTH_BIT(WIDTH_BIT)) bus5 ();
  maxpool2_if #(.SIZE(SIZE7), .POOL(POOL), .WIDTH_BIT(WIDTH_BIT)) bus7 ();

  maxpool2 #(.SIZE(SIZE), .POOL(POOL), .WIDTH_BIT(WIDTH_BIT)) u_dut5 (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus5.slave)
  );

  maxpool2 #(.SIZE(SIZE7), .POOL(POOL), .WIDTH_BIT(WIDTH_BIT)) u_dut7 (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus7.slave)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_ramp();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        bus5.inpMatrix[r][c] = 8'(r * SIZE + c);
  endtask

  task automatic fill5(input int v);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        bus5.inpMatrix[r][c] = 8'(v);
  endtask

  task automatic chk_pool5(input string tag, input int e00, input int e01,
                           input int e10, input int e11);
    chk({tag, " [0][0]"}, int'(bus5.poolOut[0][0]), e00);
    chk({tag, " [0][1]"}, int'(bus5.poolOut[0][1]), e01);
    chk({tag, " [1][0]"}, int'(bus5.poolOut[1][0]), e10);
    chk({tag, " [1][1]"}, int'(bus5.poolOut[1][1]), e11);
  endtask

  // Edge 1 is the start-sampling edge; done is expected visible after edge 21
  task automatic run5(input string tag, input bit overwrite);
    int busy_n  = 0;
    int done_n  = 0;
    int done_at = 0;
    bus5.start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 1) begin
        bus5.start = 1'b0;
        if (overwrite) fill5(127);
      end
      if (bus5.busy) busy_n++;
      if (bus5.done) begin
        done_n++;
        if (done_at == 0) done_at = i;
      end
    end
    chk({tag, " done_edge"},   done_at, 21);
    chk({tag, " busy_cycles"}, busy_n,  21);
    chk({tag, " done_pulses"}, done_n,  1);
  endtask

  bit busy_h [61];
  bit done_h [61];

  initial begin
    int busy_n;
    int done_n;
    int done_at;

    bus5.start = 1'b0;
    bus7.start = 1'b0;
    fill5(0);
    for (int r = 0; r < SIZE7; r++)
      for (int c = 0; c < SIZE7; c++)
        bus7.inpMatrix[r][c] = '0;

    // Reset state
    step();
    step();
    chk("reset busy", int'(bus5.busy), 0);
    chk("reset done", int'(bus5.done), 0);
    chk_pool5("reset pool", 0, 0, 0, 0);
    nreset = 1'b1;
    step();
    chk("idle busy", int'(bus5.busy), 0);

    // Ramp
    load_ramp();
    run5("ramp", 1'b0);
    chk_pool5("ramp", 6, 8, 16, 18);

    // Signed values
    fill5(-100);
    bus5.inpMatrix[1][0] = -8'sd3;
    bus5.inpMatrix[3][3] = -8'sd1;
    run5("signed", 1'b0);
    chk_pool5("signed", -3, -100, -100, -1);

    // Snapshot: input overwritten with 0x7F one cycle after start
    load_ramp();
    run5("snapshot", 1'b1);
    chk_pool5("snapshot", 6, 8, 16, 18);

    // Held start for 60 cycles
    load_ramp();
    bus5.start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      busy_h[i] = bus5.busy;
      done_h[i] = bus5.done;
    end
    bus5.start = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy_h[i]) busy_n++;
      if (done_h[i]) done_n++;
    end
    chk("held done_pulses",  done_n, 2);
    chk("held first_done",   int'(done_h[21]), 1);
    chk("held second_done",  int'(done_h[43]), 1);
    chk("held idle_gap",     int'(busy_h[22]), 0);
    chk("held second_rise",  int'(busy_h[23]), 1);
    chk("held busy_cycles",  busy_n, 58);
    for (int i = 0; i < 30 && bus5.busy; i++) step();
    chk("held settles idle", int'(bus5.busy), 0);
    chk_pool5("held", 6, 8, 16, 18);

    // Reset mid-scan at cycle 9
    fill5(-100);
    bus5.start = 1'b1;
    step();
    bus5.start = 1'b0;
    for (int i = 2; i <= 9; i++) step();
    nreset = 1'b0;
    #1;
    chk("midreset busy", int'(bus5.busy), 0);
    chk("midreset done", int'(bus5.done), 0);
    chk_pool5("midreset pool", 0, 0, 0, 0);
    step();
    nreset = 1'b1;
    step();
    load_ramp();
    run5("after reset", 1'b0);
    chk_pool5("after reset", 6, 8, 16, 18);

    // Odd size: row 6 and column 6 are never read
    for (int k = 0; k < SIZE7; k++) begin
      bus7.inpMatrix[6][k] = 8'sd127;
      bus7.inpMatrix[k][6] = 8'sd127;
    end
    bus7.start = 1'b1;
    done_at = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 1) bus7.start = 1'b0;
      if (bus7.done && done_at == 0) done_at = i;
    end
    chk("odd done_edge", done_at, 46);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("odd [%0d][%0d]", r, c), int'(bus7.poolOut[r][c]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/maxpool2.md
Name: maxpool2

Overview:
- 2-D max-pooling stage directly downstream of the conv2 convolution/ReLU stage.
- Consumes the conv2 feature map (SIZE x SIZE signed words) on a start pulse and takes a snapshot of it.
- Scans non-overlapping POOL x POOL windows with stride POOL, one element per clock, and writes each window maximum into a registered OUT x OUT output map.
- Signals completion with a one-cycle done pulse, so the next layer (flatten/dense) can sample it.

Parameters:
- SIZE, 5, input feature-map dimension (conv2 output dimension, 7-3+1).
- POOL, 2, pooling window edge and stride.
- WIDTH_BIT, 8, signed data word width.
- OUT (localparam), SIZE/POOL (integer floor), output map dimension.

Ports:
- clock  input  1  rising-edge clock.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  request to pool the current inpMatrix; sampled only in IDLE.
- inpMatrix  input  signed [WIDTH_BIT-1:0] x [SIZE-1:0][SIZE-1:0]  feature map from conv2.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when poolOut is complete.
- poolOut  output  signed [WIDTH_BIT-1:0] x [OUT-1:0][OUT-1:0]  pooled map.

Behaviour:
- Reset (async, nreset=0):
  - State goes to IDLE.
  - busy=0, done=0; every poolOut entry, the snapshot, all counters and the running max are cleared to 0.
  - Reset mid-operation aborts the scan with no partial result kept; poolOut reads 0.
- States: IDLE, SCAN, WRITE, DONE. Registered FSM; busy and done are registered outputs derived from the state.
- IDLE:
  - On an edge with start=1, copy all of inpMatrix into the internal snapshot.
  - Clear window row r, window col c and element index e to 0, then go to SCAN.
  - start=0 keeps the block in IDLE.
- SCAN:
  - One element per cycle: element = snapshot[r*POOL + e/POOL][c*POOL + e%POOL], e = 0..POOL*POOL-1.
  - At e=0 the running max is loaded with the element. For e>0, max <= (element > max) ? element : max, using a signed compare.
  - After e = POOL*POOL-1, go to WRITE.
- WRITE (1 cycle):
  - poolOut[r][c] <= max.
  - If c < OUT-1: c++. Else c=0 and r++.
  - If (r,c) was (OUT-1,OUT-1), go to DONE; otherwise return to SCAN with e=0.
- DONE (1 cycle): done=1, then go to IDLE. done is 0 in every other state.
- Latency:
  - Each window takes POOL*POOL+1 cycles.
  - done is high in the cycle that begins OUT*OUT*(POOL*POOL+1)+1 edges after the start-sampling edge. For the defaults that is 21 edges.
  - busy stays high from the edge after start sampling through the DONE cycle.
- Boundary conditions:
  - start while busy (SCAN/WRITE/DONE) is ignored and not queued.
  - start held high continuously restarts on the first IDLE cycle after DONE, giving exactly one IDLE cycle between runs.
  - inpMatrix changes during busy have no effect on the result (snapshot).
  - Odd SIZE: the last SIZE - OUT*POOL rows and columns are never read.
  - Ties keep the earlier element, so the value is identical either way.
  - Negative values are supported even though the ReLU upstream makes them non-negative.
- Output holding:
  - poolOut entries update only in WRITE, in raster order, and hold between runs.
  - During a new run, entries not yet rewritten keep their previous-run values.
- Arithmetic: no width growth; the max is a selection only, so there is no overflow.

Test Plan:
- Ramp (SIZE=5, POOL=2): inpMatrix[r][c]=r*5+c, pulse start -> poolOut = {{6,8},{16,18}}; done is a one-cycle pulse 21 edges after the start edge; busy is high for exactly 21 cycles.
- Signed values: all entries -100 except [1][0]=-3 and [3][3]=-1 -> poolOut = {{-3,-100},{-100,-1}}.
- Snapshot: start with the ramp, then overwrite inpMatrix with all 0x7F one cycle later -> result is still {{6,8},{16,18}}.
- Held start: start=1 for 60 cycles -> two complete runs; the second busy rises one IDLE cycle after the first done; no start is accepted while busy.
- Reset mid-scan: assert nreset=0 at cycle 9 of a ramp run -> busy=0, done=0, all poolOut=0 immediately; a subsequent start with the ramp gives {{6,8},{16,18}} with the full 21-edge latency.
- Odd-size drop (SIZE=7, POOL=2, OUT=3): row 6 and column 6 set to 127, all other entries 0 -> all nine poolOut entries are 0.
